iot_event_serializer: RTL and testbench

Front-end stage of the active IoT devices monitor. It collects asynchronous-in-time join/leave pulses from `N_DEV` device ports and serializes them into at most one `change`/`on_off` event per clock. Its output pair feeds the monitor's `change` and `on_off` inputs directly. Per-device pending registers buffer events, and a round-robin arbiter picks the next one to emit.

---
 rtl/iot_ser_pkg.sv | 19 +
 rtl/iot_event_serializer_rr_arbiter.sv | 26 ++
 rtl/iot_event_serializer.sv | 124 ++++++++++++
 tb/tb_iot_event_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/iot_ser_pkg.sv
// Shared types and constants for the IoT event serializer.
package iot_ser_pkg;

  localparam logic        DIR_JOIN      = 1'b1;
  localparam logic        DIR_LEAVE     = 1'b0;
  localparam int unsigned N_DEV_DEFAULT = 4;

  typedef struct packed {
    logic dir;
  } event_t;

  // Direction of a single (non-conflicting) event; caller guarantees join ^ leave.
  function automatic event_t to_event(input logic join_bit);
    event_t ev;
    ev.dir = join_bit ? DIR_JOIN : DIR_LEAVE;
    return ev;
  endfunction

endpackage

// File: rtl/iot_event_serializer_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or after ptr wins, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  // Scan N slots starting at ptr; the first set request is granted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iot_event_serializer.sv
// Serializes per-device join/leave pulses into at most one change/on_off event per clock.
// Optional build macro IOT_SER_DEDUP_EN: track per-device active state and silently drop
// joins to active devices and leaves from inactive ones.
module iot_event_serializer
  import iot_ser_pkg::*;
#(
  parameter int unsigned N_DEV = N_DEV_DEFAULT,
  parameter int unsigned PTR_W = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_join,
  input  logic [N_DEV-1:0] dev_leave,
  output logic             change,
  output logic             on_off,
  output logic             overflow,
  output logic             pending_any
);

  logic [N_DEV-1:0] r_pend, r_pend_dir;
  logic [PTR_W-1:0] r_ptr;
  logic             r_change, r_on_off, r_overflow, r_pending_any;

  logic [N_DEV-1:0] w_pend_d, w_dir_d;
  logic             w_ovf_d;
  logic             w_gnt_valid;
  logic [PTR_W-1:0] w_gnt_idx, w_ptr_next;

`ifdef IOT_SER_DEDUP_EN
  logic [N_DEV-1:0] r_dev_active, w_active_d;
`endif

  rr_arbiter #(
    .N     (N_DEV),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (r_pend),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // Pointer moves just past the granted device, wrapping at N_DEV-1.
  always_comb begin
    w_ptr_next = (w_gnt_idx == PTR_W'(N_DEV - 1)) ? '0 : w_gnt_idx + 1'b1;
  end

  // Next pending state: clear the grant, then apply captures per device.
  always_comb begin
    w_pend_d = r_pend;
    w_dir_d  = r_pend_dir;
    w_ovf_d  = r_overflow;
`ifdef IOT_SER_DEDUP_EN
    w_active_d = r_dev_active;
    if (w_gnt_valid) w_active_d[w_gnt_idx] = r_pend_dir[w_gnt_idx];
`endif
    if (w_gnt_valid) w_pend_d[w_gnt_idx] = 1'b0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      event_t ev;
      logic   granted;
      granted = w_gnt_valid && (32'(w_gnt_idx) == i);
      ev      = to_event(dev_join[i]);
      // Simultaneous join and leave on one device are both discarded.
      if (dev_join[i] ^ dev_leave[i]) begin
`ifdef IOT_SER_DEDUP_EN
        // Granted device: its effective state becomes the emitted direction.
        if (granted) begin
          if (ev.dir != r_pend_dir[i]) begin
            w_pend_d[i] = 1'b1;
            w_dir_d[i]  = ev.dir;
          end
        end else if (r_pend[i]) begin
          if (ev.dir != r_pend_dir[i]) w_pend_d[i] = 1'b0;
        end else if (ev.dir != r_dev_active[i]) begin
          w_pend_d[i] = 1'b1;
          w_dir_d[i]  = ev.dir;
        end
`else
        if (granted || !r_pend[i]) begin
          w_pend_d[i] = 1'b1;
          w_dir_d[i]  = ev.dir;
        end else if (ev.dir != r_pend_dir[i]) begin
          w_pend_d[i] = 1'b0;
        end else begin
          w_ovf_d = 1'b1;
        end
`endif
      end
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend        <= '0;
      r_pend_dir    <= '0;
      r_ptr         <= '0;
      r_change      <= 1'b0;
      r_on_off      <= 1'b0;
      r_overflow    <= 1'b0;
      r_pending_any <= 1'b0;
`ifdef IOT_SER_DEDUP_EN
      r_dev_active  <= '0;
`endif
    end else begin
      r_pend        <= w_pend_d;
      r_pend_dir    <= w_dir_d;
      r_overflow    <= w_ovf_d;
      r_change      <= w_gnt_valid;
      r_on_off      <= w_gnt_valid & r_pend_dir[w_gnt_idx];
      r_pending_any <= |w_pend_d;
      if (w_gnt_valid) r_ptr <= w_ptr_next;
`ifdef IOT_SER_DEDUP_EN
      r_dev_active  <= w_active_d;
`endif
    end
  end

  assign change      = r_change;
  assign on_off      = r_on_off;
  assign overflow    = r_overflow;
  assign pending_any = r_pending_any;

endmodule

// File: tb/tb_iot_event_serializer.sv
// Directed bench for iot_event_serializer (N_DEV = 4).
module tb_iot_event_serializer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] dev_join, dev_leave;
  logic         change, on_off, overflow, pending_any;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned pulses;

`ifdef IOT_SER_DEDUP_EN
  localparam logic [31:0] EXP_DUP_OVF   = 32'd0;
  localparam logic [31:0] EXP_LONE_CHG  = 32'd0;
  localparam logic [31:0] EXP_LONE_PEND = 32'd0;
`else
  localparam logic [31:0] EXP_DUP_OVF   = 32'd1;
  localparam logic [31:0] EXP_LONE_CHG  = 32'd1;
  localparam logic [31:0] EXP_LONE_PEND = 32'd1;
`endif

  always #5 clk = ~clk;

  iot_event_serializer #(
    .N_DEV (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_join    (dev_join),
    .dev_leave   (dev_leave),
    .change      (change),
    .on_off      (on_off),
    .overflow    (overflow),
    .pending_any (pending_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one edge; outputs are sampled 1 time unit after that edge.
  task automatic step(input logic [N-1:0] j, input logic [N-1:0] l);
    dev_join  = j;
    dev_leave = l;
    @(posedge clk);
    #1;
    dev_join  = '0;
    dev_leave = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, '0);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic c, input logic o, input logic pa);
    check({tag, ".change"}, 32'(change), 32'(c));
    check({tag, ".on_off"}, 32'(on_off), 32'(o));
    check({tag, ".pend"}, 32'(pending_any), 32'(pa));
  endtask

  initial begin
    rst       = 1'b1;
    dev_join  = '0;
    dev_leave = '0;

    // Reset held 3 edges with all joins asserted: everything ignored.
    repeat (3) step(4'hF, 4'h0);
    rst = 1'b0;
    expect_out("rst", 1'b0, 1'b0, 1'b0);
    check("rst.ovf", 32'(overflow), 32'd0);
    step('0, '0);
    expect_out("rst_idle", 1'b0, 1'b0, 1'b0);

    // Single join on device 2: change two edges after the input.
    step(4'b0100, '0);
    expect_out("j2_cap", 1'b0, 1'b0, 1'b1);
    step('0, '0);
    expect_out("j2_emit", 1'b1, 1'b1, 1'b0);
    step('0, '0);
    expect_out("j2_done", 1'b0, 1'b0, 1'b0);

    // Burst of four joins, then a leave on device 0 once the pointer wrapped to 0.
    do_reset();
    step(4'hF, '0);
    expect_out("burst_cap", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step('0, '0);
      expect_out($sformatf("burst%0d", k), 1'b1, 1'b1, (k < 3));
    end
    step('0, '0);
    expect_out("burst_end", 1'b0, 1'b0, 1'b0);
    step('0, 4'b0001);
    expect_out("wrap_cap", 1'b0, 1'b0, 1'b1);
    step('0, '0);
    expect_out("wrap_emit", 1'b1, 1'b0, 1'b0);

    // Round-robin order: pointer at 3 after granting 2, so order is 0,1,2.
    do_reset();
    step(4'b0101, '0);
    step('0, '0);
    expect_out("ord_a", 1'b1, 1'b1, 1'b1);
    step(4'b0010, 4'b0101);
    expect_out("ord_b", 1'b1, 1'b1, 1'b1);
    step('0, '0);
    expect_out("ord_c", 1'b1, 1'b0, 1'b1);
    step('0, '0);
    expect_out("ord_d", 1'b1, 1'b1, 1'b1);
    step('0, '0);
    expect_out("ord_e", 1'b1, 1'b0, 1'b0);

    // Cancel: leave on device 1 while its join is still pending behind device 0.
    do_reset();
    step(4'b0011, '0);
    step('0, 4'b0010);
    expect_out("cxl_a", 1'b1, 1'b1, 1'b0);
    step('0, '0);
    expect_out("cxl_b", 1'b0, 1'b0, 1'b0);
    check("cxl.ovf", 32'(overflow), 32'd0);

    // Duplicate joins on device 3 while it waits behind 0..2.
    do_reset();
    step(4'hF, '0);
    pulses = 0;
    step(4'b1000, '0);
    pulses += 32'(change);
    check("dup.ovf1", 32'(overflow), EXP_DUP_OVF);
    step(4'b1000, '0);
    pulses += 32'(change);
    repeat (3) begin
      step('0, '0);
      pulses += 32'(change);
    end
    check("dup.pulses", pulses, 32'd4);
    check("dup.ovf_sticky", 32'(overflow), EXP_DUP_OVF);
    check("dup.pend", 32'(pending_any), 32'd0);
    do_reset();
    check("dup.ovf_rst", 32'(overflow), 32'd0);

    // New event on the device being granted re-arms it in the opposite direction.
    do_reset();
    step(4'b0001, '0);
    step('0, 4'b0001);
    expect_out("ge_a", 1'b1, 1'b1, 1'b1);
    check("ge.ovf", 32'(overflow), 32'd0);
    step('0, '0);
    expect_out("ge_b", 1'b1, 1'b0, 1'b0);

    // Join and leave together are discarded.
    do_reset();
    step(4'b0100, 4'b0100);
    expect_out("both_a", 1'b0, 1'b0, 1'b0);
    step('0, '0);
    expect_out("both_b", 1'b0, 1'b0, 1'b0);

    // Reset right after the first pulse of a burst kills the rest.
    do_reset();
    step(4'hF, '0);
    step('0, '0);
    expect_out("mb_first", 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step('0, '0);
    rst = 1'b0;
    expect_out("mb_rst", 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (4) begin
      step('0, '0);
      pulses += 32'(change);
    end
    check("mb.pulses", pulses, 32'd0);

    // Leave on a never-joined device 0.
    do_reset();
    step('0, 4'b0001);
    check("lone.pend", 32'(pending_any), EXP_LONE_PEND);
    step('0, '0);
    check("lone.change", 32'(change), EXP_LONE_CHG);
    check("lone.on_off", 32'(on_off), 32'd0);
    check("lone.ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
